// File: rtl/noc_input_unit.sv
// -----------------------------------------------------------------------------
// noc_input_unit
//   Router input port. Buffers incoming flits in a small circular FIFO,
//   computes the XY (X-first) route of each packet's head flit, raises a
//   one-hot request toward the chosen output's arbiter and forwards flits in
//   the cycles where that arbiter grants. One credit is returned upstream for
//   every flit removed from the buffer (forwarded or discarded).
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   in_valid      upstream flit present this cycle
//   in_flit       incoming flit, type in the two MSBs
//   credit_out    one-cycle pulse per dequeued flit
//   req           one-hot request to the output arbiters
//   grant_in      this input's grant bit from each output arbiter
//   out_valid     flit driven to the crossbar this cycle
//   out_flit      buffer head flit (undefined while empty)
//   out_port      one-hot selected output of the current packet
//   count         buffer occupancy
//   overflow_err  sticky: flit arrived while the buffer was full
//   proto_err     sticky: BODY/TAIL at buffer head with no open packet
// -----------------------------------------------------------------------------
module noc_input_unit #(
  parameter int N_PORTS = 5,
  parameter int DEPTH   = 4,
  parameter int FLIT_W  = 32,
  parameter int X_W     = 3,
  parameter int Y_W     = 3,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       credit_out,
  output logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS-1:0]         grant_in,
  output logic                       out_valid,
  output logic [FLIT_W-1:0]          out_flit,
  output logic [N_PORTS-1:0]         out_port,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACTIVE
  } state_t;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  state_t             state_reg;
  logic [N_PORTS-1:0] port_reg;
  logic               overflow_reg;
  logic               proto_reg;

  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_type;
  logic               head_is_start;
  logic               empty;
  logic               full;
  logic               wr_en;
  logic               deq;
  logic               fwd;
  logic               granted;
  logic [N_PORTS-1:0] req_c;
  logic [N_PORTS-1:0] route;
  logic [X_W-1:0]     dest_x;
  logic [Y_W-1:0]     dest_y;

  assign head          = mem[rd_ptr_reg];
  assign head_type     = head[FLIT_W-1 -: 2];
  assign head_is_start = (head_type == T_HEAD) || (head_type == T_SINGLE);
  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CW'(DEPTH));
  assign wr_en         = in_valid && !full;
  // Only the grant bit matching the packet's own output counts.
  assign granted       = |(grant_in & port_reg);

  assign dest_x = head[X_W-1:0];
  assign dest_y = head[X_W+Y_W-1:X_W];

  // XY routing, X dimension resolved first, unsigned comparisons.
  always_comb begin
    route = '0;
    if (dest_x > X_W'(CUR_X))
      route[2] = 1'b1;        // E
    else if (dest_x < X_W'(CUR_X))
      route[4] = 1'b1;        // W
    else if (dest_y > Y_W'(CUR_Y))
      route[1] = 1'b1;        // N
    else if (dest_y < Y_W'(CUR_Y))
      route[3] = 1'b1;        // S
    else
      route[0] = 1'b1;        // local
  end

  // Request / dequeue decode. Gated by rst so nothing leaves the block (and no
  // credit is returned) in a reset cycle.
  always_comb begin
    req_c = '0;
    deq   = 1'b0;
    fwd   = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_IDLE: begin
          // A stray BODY/TAIL is dropped, but its buffer slot is still credited.
          if (!empty && !head_is_start)
            deq = 1'b1;
        end
        S_REQ: begin
          req_c = port_reg;
          if (granted) begin
            deq = 1'b1;
            fwd = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!empty) begin
            req_c = port_reg;
            if (granted) begin
              deq = 1'b1;
              fwd = 1'b1;
            end
          end
        end
        default: begin
          req_c = '0;
        end
      endcase
    end
  end

  assign req          = req_c;
  assign out_valid    = fwd;
  assign credit_out   = deq;
  assign out_flit     = head;
  assign out_port     = port_reg;
  assign count        = count_reg;
  assign overflow_err = overflow_reg;
  assign proto_err    = proto_reg;

  // Flit storage; contents need no reset since occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= S_IDLE;
      port_reg     <= '0;
      overflow_reg <= 1'b0;
      proto_reg    <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(wr_en) - CW'(deq);

      // A read in the same cycle does not make room for a flit arriving full.
      if (in_valid && full)
        overflow_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (!empty) begin
            if (head_is_start) begin
              port_reg  <= route;
              state_reg <= S_REQ;
            end else begin
              proto_reg <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (granted)
            state_reg <= (head_type == T_SINGLE) ? S_IDLE : S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!empty && granted && head_type == T_TAIL)
            state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// -----------------------------------------------------------------------------
// tb_noc_input_unit
//   Directed scenarios with literal expectations followed by randomized
//   traffic. A queue-based packet model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_noc_input_unit;

  localparam int NP = 5;
  localparam int DEPTH = 4;
  localparam int FW = 32;
  localparam int CX = 1;
  localparam int CY = 1;

  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] SNGL = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          credit_out;
  logic [NP-1:0] req;
  logic [NP-1:0] grant_in;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic [NP-1:0] out_port;
  logic [2:0]    count;
  logic          overflow_err;
  logic          proto_err;

  logic          tie = 1'b0;
  logic [NP-1:0] grant_drv = '0;

  assign grant_in = tie ? req : grant_drv;

  int checks = 0;
  int errors = 0;

  noc_input_unit #(
    .N_PORTS(NP), .DEPTH(DEPTH), .FLIT_W(FW), .X_W(3), .Y_W(3),
    .CUR_X(CX), .CUR_Y(CY)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .credit_out(credit_out), .req(req), .grant_in(grant_in),
    .out_valid(out_valid), .out_flit(out_flit), .out_port(out_port),
    .count(count), .overflow_err(overflow_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [23:0] pay;
    logic [2:0] xx;
    logic [2:0] yy;
    pay = 24'($urandom);
    xx = 3'(x);
    yy = 3'(y);
    return {t, pay, yy, xx};
  endfunction

  function automatic int route_of(input logic [FW-1:0] f);
    int dx;
    int dy;
    dx = int'(f[2:0]);
    dy = int'(f[5:3]);
    if (dx > CX) return 2;
    if (dx < CX) return 4;
    if (dy > CY) return 1;
    if (dy < CY) return 3;
    return 0;
  endfunction

  // ---------------- behavioural model + per-cycle comparison ----------------
  logic [FW-1:0] q[$];
  bit            m_valid = 0;
  bit            m_route = 0;   // head seen, route chosen, waiting for grant
  bit            m_open  = 0;   // head forwarded, packet still open
  int            m_port  = 0;
  bit            m_oerr  = 0;
  bit            m_perr  = 0;

  always @(negedge clk) begin
    logic [NP-1:0] e_req;
    bit e_ov, e_cr, pop, full_now, n_route, n_open, n_perr;
    logic [1:0] ht;
    int n_port;
    e_req = '0;
    e_ov = 0;
    e_cr = 0;
    pop = 0;
    if (rst) begin
      check("rst_req", 32'(req), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_credit", 32'(credit_out), 32'd0);
      q.delete();
      m_route = 0;
      m_open = 0;
      m_port = 0;
      m_oerr = 0;
      m_perr = 0;
      m_valid = 1;
    end else if (m_valid) begin
      n_route = m_route;
      n_open = m_open;
      n_perr = m_perr;
      n_port = m_port;
      ht = (q.size() > 0) ? q[0][31:30] : 2'b00;
      if (!m_route && !m_open) begin
        if (q.size() > 0) begin
          if (ht == BODY || ht == TAIL) begin
            e_cr = 1;
            pop = 1;
            n_perr = 1;
          end else begin
            n_route = 1;
            n_port = route_of(q[0]);
          end
        end
      end else if (m_route) begin
        e_req = NP'(1 << m_port);
        if (grant_in[m_port]) begin
          e_ov = 1;
          e_cr = 1;
          pop = 1;
          n_route = 0;
          n_open = (ht == HEAD);
        end
      end else if (q.size() > 0) begin
        e_req = NP'(1 << m_port);
        if (grant_in[m_port]) begin
          e_ov = 1;
          e_cr = 1;
          pop = 1;
          if (ht == TAIL) n_open = 0;
        end
      end

      check("req", 32'(req), 32'(e_req));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("credit_out", 32'(credit_out), 32'(e_cr));
      check("count", 32'(count), 32'(q.size()));
      check("overflow_err", 32'(overflow_err), 32'(m_oerr));
      check("proto_err", 32'(proto_err), 32'(m_perr));
      if (m_route || m_open)
        check("out_port", 32'(out_port), 32'(1 << m_port));
      if (e_ov) begin
        check("out_flit", out_flit, q[0]);
        $display("xfer flit=%h port=%0d t=%0t", q[0], m_port, $time);
      end else if (e_cr) begin
        $display("drop stray flit=%h t=%0t", q[0], $time);
      end

      full_now = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (in_valid) begin
        if (!full_now) q.push_back(in_flit);
        else m_oerr = 1;
      end
      m_route = n_route;
      m_open = n_open;
      m_perr = n_perr;
      m_port = n_port;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tie = 1'b0;
    grant_drv = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [FW-1:0] f);
    in_valid = 1'b1;
    in_flit = f;
  endtask

  initial begin
    logic [FW-1:0] f0;
    logic [FW-1:0] h;
    int pkt_left;
    int r;

    step();
    do_reset();

    // T1: single-flit packet eastward, grant tied to req.
    tie = 1'b1;
    f0 = mk(SNGL, 3, 1);
    send(f0);                          // cycle 0
    step(); in_valid = 1'b0;           // cycle 1
    step();                            // cycle 2
    @(negedge clk);
    check("t1_req", 32'(req), 32'b00100);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_credit", 32'(credit_out), 32'd1);
    check("t1_flit", out_flit, f0);
    step();                            // cycle 3
    @(negedge clk);
    check("t1_count", 32'(count), 32'd0);
    step();

    // T2: 4-flit packet southward, grant withheld then given.
    tie = 1'b0;
    grant_drv = '0;
    h = mk(HEAD, 1, 0);
    send(h); step();
    send(mk(BODY, 0, 0)); step();
    send(mk(BODY, 0, 0)); step();
    send(mk(TAIL, 0, 0)); step();
    in_valid = 1'b0;                   // cycle 4
    @(negedge clk);
    check("t2_req_held", 32'(req), 32'b01000);
    check("t2_count", 32'(count), 32'd4);
    step();                            // cycle 5
    grant_drv = 5'b01000;
    @(negedge clk);
    check("t2_head_out", 32'(out_valid), 32'd1);
    check("t2_head_flit", out_flit, h);
    repeat (4) step();                 // cycle 9
    @(negedge clk);
    check("t2_req_after_tail", 32'(req), 32'd0);
    check("t2_drained", 32'(count), 32'd0);
    step();
    grant_drv = '0;

    // T3: overflow while full, then drain in order.
    do_reset();
    send(mk(HEAD, 1, 0)); step();
    send(mk(BODY, 0, 0)); step();
    send(mk(BODY, 0, 0)); step();
    send(mk(TAIL, 0, 0)); step();
    send(mk(BODY, 0, 0)); step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_overflow", 32'(overflow_err), 32'd1);
    step();
    grant_drv = 5'b01000;
    repeat (6) step();
    @(negedge clk);
    check("t3_drained", 32'(count), 32'd0);
    step();

    // T4: stray TAIL in IDLE, then a local packet.
    do_reset();
    tie = 1'b1;
    send(mk(TAIL, 0, 0)); step();      // cycle 1
    send(mk(HEAD, 1, 1));
    @(negedge clk);
    check("t4_stray_credit", 32'(credit_out), 32'd1);
    check("t4_stray_no_valid", 32'(out_valid), 32'd0);
    step();                            // cycle 2
    send(mk(TAIL, 0, 0));
    @(negedge clk);
    check("t4_proto_err", 32'(proto_err), 32'd1);
    step();                            // cycle 3
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_req_local", 32'(req), 32'b00001);
    repeat (4) step();

    // T5: grant bits outside out_port are ignored.
    do_reset();
    grant_drv = 5'b11011;
    send(mk(SNGL, 3, 1)); step();
    in_valid = 1'b0;
    step(); step();                    // cycle 3
    @(negedge clk);
    check("t5_no_valid", 32'(out_valid), 32'd0);
    check("t5_req", 32'(req), 32'b00100);
    check("t5_count", 32'(count), 32'd1);
    step();                            // cycle 4
    grant_drv = 5'b00100;
    @(negedge clk);
    check("t5_valid", 32'(out_valid), 32'd1);
    step();
    grant_drv = '0;
    @(negedge clk);
    check("t5_count_after", 32'(count), 32'd0);
    step();

    // T6: reset mid-packet with flits buffered, then a fresh packet.
    do_reset();
    grant_drv = 5'b00100;
    send(mk(HEAD, 3, 1)); step();
    send(mk(BODY, 0, 0)); step();
    send(mk(BODY, 0, 0)); step();      // cycle 3
    in_valid = 1'b0;
    grant_drv = '0;
    @(negedge clk);
    check("t6_buffered", 32'(count), 32'd2);
    check("t6_req_active", 32'(req), 32'b00100);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_count", 32'(count), 32'd0);
    check("t6_req", 32'(req), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_credit", 32'(credit_out), 32'd0);
    check("t6_ovf", 32'(overflow_err), 32'd0);
    check("t6_proto", 32'(proto_err), 32'd0);
    step();
    tie = 1'b1;
    send(mk(SNGL, 1, 3)); step();
    in_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic.
    pkt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      tie = 1'($urandom_range(0, 1));
      grant_drv = NP'($urandom);
      if (rst) begin
        pkt_left = 0;
        in_valid = 1'b0;
      end else if ($urandom_range(0, 99) < 60) begin
        if (pkt_left == 0) begin
          r = int'($urandom_range(0, 9));
          if (r == 0)
            send(mk($urandom_range(0, 1) ? TAIL : BODY, 0, 0));
          else if (r < 4)
            send(mk(SNGL, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
          else begin
            send(mk(HEAD, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
            pkt_left = int'($urandom_range(1, 4));
          end
        end else begin
          pkt_left--;
          send(mk(pkt_left == 0 ? TAIL : BODY, 0, 0));
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
